// File: rtl/psu_pchinfo_buf_pkg.sv
// Shared constants and types for the PSU patch-info buffer slice.
package psu_pchinfo_buf_pkg;

    localparam int unsigned PCHINFO_BW    = 16;
    localparam int unsigned PCHBUF_DEPTH  = 16;
    localparam int unsigned PCHBUF_PTR_BW = $clog2(PCHBUF_DEPTH);

    // Read-side action chosen each cycle from rd_adv / rd_release / rdlast.
    typedef enum logic [1:0] {
        RD_HOLD   = 2'd0,
        RD_STEP   = 2'd1,
        RD_REPLAY = 2'd2,
        RD_FREE   = 2'd3
    } rd_op_e;

endpackage

// File: rtl/psu_pchinfo_buf_if.sv
// Decoder-write / controller-read bundle between the decoder, buffer and psu_ctrl.
interface psu_pchinfo_buf_if #(
    parameter int unsigned PCHINFO_BW = 16
);
    logic                  flush;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [PCHINFO_BW-1:0] wr_data;
    logic                  wr_last;
    logic                  rd_adv;
    logic                  rd_release;
    logic [PCHINFO_BW-1:0] rd_data;
    logic                  pchinfo_valid;
    logic                  pchinfo_rdlast;
    logic                  pchinfo_nextready;
    logic                  ovf_err;

    modport master (
        output flush, wr_valid, wr_data, wr_last, rd_adv, rd_release,
        input  wr_ready, rd_data, pchinfo_valid, pchinfo_rdlast,
               pchinfo_nextready, ovf_err
    );

    modport slave (
        input  flush, wr_valid, wr_data, wr_last, rd_adv, rd_release,
        output wr_ready, rd_data, pchinfo_valid, pchinfo_rdlast,
               pchinfo_nextready, ovf_err
    );
endinterface

// File: rtl/psu_pchinfo_buf_mem.sv
// Patch-info register file: one synchronous write port, one combinational read port.
module psu_pchbuf_mem #(
    parameter int unsigned WIDTH  = 17,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned PTR_BW = 4
) (
    input  logic              clk,
    input  logic              i_we,
    input  logic [PTR_BW-1:0] i_waddr,
    input  logic [WIDTH-1:0]  i_wdata,
    input  logic [PTR_BW-1:0] i_raddr,
    output logic [WIDTH-1:0]  o_rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/psu_pchinfo_buf.sv
// Patch-info buffer: stores per-instruction patch groups, replays each group per
// round and frees it when psu_ctrl finishes the opcode.
module psu_pchinfo_buf
    import psu_pchinfo_buf_pkg::*;
#(
    parameter int unsigned PCHINFO_BW = psu_pchinfo_buf_pkg::PCHINFO_BW,
    parameter int unsigned DEPTH      = PCHBUF_DEPTH,
    parameter int unsigned PTR_BW     = $clog2(DEPTH)
) (
    input  logic               clk,
    input  logic               rst,
    psu_pchinfo_buf_if.slave   bus
);

    localparam int unsigned       CNT_BW = PTR_BW + 1;
    localparam logic [CNT_BW-1:0] FULL   = CNT_BW'(DEPTH);

    logic [PTR_BW-1:0] r_wr_ptr;
    logic [PTR_BW-1:0] r_rd_ptr;
    logic [PTR_BW-1:0] r_grp_ptr;
    logic [CNT_BW-1:0] r_occ;
    logic [CNT_BW-1:0] r_grp_cnt;
    logic              r_ovf_err;

    logic [PCHINFO_BW:0] w_rd_word;
    logic                w_valid;
    logic                w_rd_last;
    logic                w_wr_acc;
    logic                w_free;
    rd_op_e              w_rd_op;
    logic [CNT_BW-1:0]   w_grp_len;
    logic [CNT_BW-1:0]   w_occ_next;
    logic [CNT_BW-1:0]   w_grp_cnt_next;

    psu_pchbuf_mem #(
        .WIDTH  (PCHINFO_BW + 1),
        .DEPTH  (DEPTH),
        .PTR_BW (PTR_BW)
    ) u_mem (
        .clk     (clk),
        .i_we    (w_wr_acc && !bus.flush),
        .i_waddr (r_wr_ptr),
        .i_wdata ({bus.wr_last, bus.wr_data}),
        .i_raddr (r_rd_ptr),
        .o_rdata (w_rd_word)
    );

    assign w_valid   = (r_grp_cnt != '0);
    assign w_rd_last = w_rd_word[PCHINFO_BW];
    assign w_wr_acc  = bus.wr_valid && (r_occ != FULL);
    assign w_free    = (w_rd_op == RD_FREE);

    always_comb begin
        w_rd_op = RD_HOLD;
        if (bus.rd_adv && w_valid) begin
            if (!w_rd_last) begin
                w_rd_op = RD_STEP;
            end else if (!bus.rd_release) begin
                w_rd_op = RD_REPLAY;
            end else begin
                w_rd_op = RD_FREE;
            end
        end
    end

    // Space is counted from grp_ptr: replayed entries stay resident until freed.
    always_comb begin
        w_grp_len      = {1'b0, r_rd_ptr - r_grp_ptr} + CNT_BW'(1);
        w_occ_next     = r_occ + CNT_BW'(w_wr_acc) - (w_free ? w_grp_len : '0);
        w_grp_cnt_next = r_grp_cnt + CNT_BW'(w_wr_acc && bus.wr_last) - CNT_BW'(w_free);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_grp_ptr <= '0;
            r_occ     <= '0;
            r_grp_cnt <= '0;
            r_ovf_err <= 1'b0;
        end else if (bus.flush) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_grp_ptr <= '0;
            r_occ     <= '0;
            r_grp_cnt <= '0;
            r_ovf_err <= 1'b0;
        end else begin
            if (w_wr_acc) begin
                r_wr_ptr <= r_wr_ptr + PTR_BW'(1);
            end
            case (w_rd_op)
                RD_STEP:   r_rd_ptr <= r_rd_ptr + PTR_BW'(1);
                RD_REPLAY: r_rd_ptr <= r_grp_ptr;
                RD_FREE: begin
                    r_rd_ptr  <= r_rd_ptr + PTR_BW'(1);
                    r_grp_ptr <= r_rd_ptr + PTR_BW'(1);
                end
                default: ;
            endcase
            r_occ     <= w_occ_next;
            r_grp_cnt <= w_grp_cnt_next;
            if (r_occ == FULL && r_grp_cnt == '0) begin
                r_ovf_err <= 1'b1;
            end
        end
    end

    assign bus.wr_ready          = (r_occ != FULL);
    assign bus.pchinfo_valid     = w_valid;
    assign bus.rd_data           = w_valid ? w_rd_word[PCHINFO_BW-1:0] : '0;
    assign bus.pchinfo_rdlast    = w_valid && w_rd_last;
    assign bus.pchinfo_nextready = !bus.rd_release || (r_grp_cnt >= CNT_BW'(2));
    assign bus.ovf_err           = r_ovf_err;

endmodule
